// File: rtl/muldiv_pkg.sv
// Shared operation/state encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Operations whose operands are two's-complement.
  function automatic logic is_signed(op_t op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Operations that go through the divider datapath.
  function automatic logic is_div(op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational iteration of unsigned restoring division.
// The quotient register doubles as the dividend shift register: its MSB is
// shifted into the partial remainder and the new quotient bit enters at the LSB.
module restoring_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             q_bit;

  // Trial subtraction; keep it only if the shifted remainder did not go negative.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {2'b00, divisor_i};
    q_bit   = ~diff[WIDTH+1];
    rem_o   = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    quo_o   = {quo_i[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Multiplies are radix-2 shift-add, divides are restoring; both work on
// magnitudes and fix up signs in a final FIX cycle that also writes HI/LO.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic               neg_q, neg_d;      // result (product / quotient) negative
  logic               rsign_q, rsign_d;  // dividend negative -> remainder negative
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // product accumulator
  logic [WIDTH:0]     rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   shreg_q, shreg_d;  // multiplier, or dividend/quotient
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  op_t                op_in;
  logic               sgn_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quo;

  assign op_in   = op_t'(Op);
  assign sgn_in  = is_signed(op_in);
  assign mag_a   = (sgn_in && A[WIDTH-1]) ? -A : A;
  assign mag_b   = (sgn_in && B[WIDTH-1]) ? -B : B;
  assign prod    = neg_q ? -acc_q : acc_q;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (shreg_q[0] ? {1'b0, opnd_q} : '0);

  restoring_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (shreg_q),
    .divisor_i (opnd_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

  // Next-state and datapath update; Flush of an in-flight op overrides last.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rsign_d = rsign_q;
    div0_d  = div0_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opnd_d  = opnd_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          if (op_in == OP_MTHI) begin
            hi_d   = A;
            done_d = 1'b1;
          end else if (op_in == OP_MTLO) begin
            lo_d   = A;
            done_d = 1'b1;
          end else begin
            op_d    = op_in;
            neg_d   = sgn_in & (A[WIDTH-1] ^ B[WIDTH-1]);
            rsign_d = sgn_in & A[WIDTH-1];
            cnt_d   = CW'(WIDTH);
            div0_d  = 1'b0;
            if (is_div(op_in)) begin
              opnd_d  = mag_b;
              shreg_d = mag_a;
              rem_d   = '0;
              if (B == '0) begin
                // Raw dividend is parked here so FIX can return it in HI.
                div0_d  = 1'b1;
                shreg_d = A;
                state_d = FIX;
              end else begin
                state_d = DIV;
              end
            end else begin
              opnd_d  = mag_a;
              shreg_d = mag_b;
              acc_d   = '0;
              state_d = MUL;
            end
          end
        end
      end

      MUL: begin
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end

      DIV: begin
        rem_d   = step_rem;
        shreg_d = step_quo;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div0_q) begin
          hi_d = shreg_q;
          lo_d = '1;
        end else if (is_div(op_q)) begin
          lo_d = neg_q ? -shreg_q : shreg_q;
          hi_d = rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end else if (op_q == OP_MADD) begin
          {hi_d, lo_d} = {hi_q, lo_q} + prod;
        end else if (op_q == OP_MSUB) begin
          {hi_d, lo_d} = {hi_q, lo_q} - prod;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end

      default: state_d = IDLE;
    endcase

    if (Flush && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and architectural HI/LO registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q    <= OP_MULT;
      neg_q   <= 1'b0;
      rsign_q <= 1'b0;
      div0_q  <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      opnd_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      neg_q   <= neg_d;
      rsign_q <= rsign_d;
      div0_q  <= div0_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opnd_q  <= opnd_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS pipeline. It replaces the single-cycle multiply path and separate HI/LO register pair in the EX/MEM stages. Signed and unsigned multiply and divide run over multiple cycles, and it adds multiply-accumulate/subtract and direct HI/LO writes. While an operation is in flight, a busy signal lets the hazard unit stall dependent instructions.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be even and ≥ 8.
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: launch the operation in `Op`; sampled only when `Busy`=0.
- `Op` in 3: operation code (package encoding).
- `A` in WIDTH: rs operand (multiplicand / dividend / MTHI-MTLO data).
- `B` in WIDTH: rt operand (multiplier / divisor).
- `Flush` in 1: abort the in-flight operation; HI/LO unchanged.
- `Busy` out 1: operation in progress; the hazard unit stalls on any MFHI/MFLO/mul/div while high.
- `Done` out 1: one-cycle pulse on the cycle HI/LO take the new result.
- `Hi` out WIDTH: architectural HI register.
- `Lo` out WIDTH: architectural LO register.

## Operation
- Op codes:
  - MULT=0, MULTU=1, DIV=2, DIVU=3: full-width result to {Hi,Lo}.
  - MADD=4, MSUB=5: signed; {Hi,Lo} ± A*B, modulo 2^(2·WIDTH).
  - MTHI=6, MTLO=7: A written to the named register only.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE + Start + MTHI/MTLO: the write happens at this edge. `Done` pulses next cycle. `Busy` stays 0.
  - IDLE + Start + mul op: latch \|A\|, \|B\| (or raw values for MULTU) and result signs. Clear the 2·WIDTH product accumulator. Counter = WIDTH. Go to MUL.
  - IDLE + Start + div op: latch magnitudes and signs; remainder = 0; counter = WIDTH; go to DIV.
  - MUL: shift-add radix-2, one multiplier bit per cycle. Go to FIX when the counter reaches 0.
  - DIV: restoring division, one quotient bit per cycle. Go to FIX when the counter reaches 0.
  - FIX, multiply ops:
    - Negate the product if the sign flag is set.
    - MULT/MULTU: load {Hi,Lo}.
    - MADD/MSUB: add/subtract into {Hi,Lo}.
  - FIX, divide ops:
    - Lo = quotient, negated if dividend and divisor signs differ.
    - Hi = remainder, carrying the dividend's sign (truncate toward zero).
  - FIX always: assert `Done`, go to IDLE.
- Divide by zero, detected at Start: skip DIV and go straight to FIX. Hi = A, Lo = all ones.
- Signed DIV of most-negative by −1: Lo = most-negative, Hi = 0 (natural wrap, no trap).
- `Start` while `Busy`=1: ignored; no queueing.
- `Flush` in MUL/DIV/FIX: return to IDLE next edge, no `Done`, Hi/Lo untouched.
- `Flush` in IDLE together with `Start`: the start is discarded.
- `Reset` has priority over everything at the edge, including mid-operation: state IDLE, Hi=0, Lo=0, Busy=0, Done=0, accumulator and counter cleared.

## Timing
- `Busy` = (state ≠ IDLE), combinational from state. It rises the cycle after the accepted Start.
- Mul/div latency: Start at edge 0; edges 1..WIDTH iterate; edge WIDTH+1 is FIX, which updates Hi/Lo and pulses `Done`. `Busy` drops the same cycle.
- Divide-by-zero latency: 2 edges (Start → FIX → IDLE). Hi/Lo updated at edge 1.
- MTHI/MTLO: Hi/Lo visible the cycle after Start; `Done` high that same cycle.
- Back-to-back issue: a new Start is accepted in the cycle `Busy` falls.
- Hi/Lo are registered outputs; no combinational path from A/B to Hi/Lo.

## Structure
- Package `muldiv_pkg`: `op_t` enum (8 codes above), `state_t` enum, and function `is_signed(op_t)`.
- Sub-module `restoring_div_step`: combinational single iteration. Inputs remainder, quotient, and divisor. Outputs the next remainder and quotient. Instantiated once.
- Counter width $clog2(WIDTH+1). The product accumulator is 2·WIDTH; the remainder register is WIDTH+1.

## Test plan (WIDTH=32)
- Reset, then MULT A=0xFFFFFFFD (−3), B=5 → after 33 edges Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; `Done` pulses once; `Busy` high for exactly 33 cycles.
- DIVU A=100, B=7 → Lo=14, Hi=2. Then DIV A=−7, B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- MTLO 10, MTHI 0, MADD A=3, B=4 → Hi=0, Lo=22. Then MSUB A=0xFFFFFFFF (−1), B=23 → Hi=0, Lo=45.
- DIV A=0x12345678, B=0 → Hi=0x12345678, Lo=0xFFFFFFFF after 2 edges. DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Preload Hi=Lo=0xAAAAAAAA. Start MULTU, assert `Flush` at cycle 10 → Busy=0 next cycle, no `Done`, Hi/Lo still 0xAAAAAAAA. A `Start` pulsed at cycle 5 is ignored.
- Reset asserted mid-DIV → Hi=Lo=0, Busy=0 next edge. A subsequent MULTU 0xFFFFFFFF×0xFFFFFFFF gives Hi=0xFFFFFFFE, Lo=0x00000001.
